interrupt_source_ctrl: RTL and testbench

//  Initiator side of the datapath interrupt interface. Queues interrupt requests from two peripheral

---
 rtl/interrupt_source_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_interrupt_source_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_source_ctrl.sv
// rtl/interrupt_source_ctrl.sv - two-line prioritised interrupt initiator with ack/timeout response
module interrupt_source_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req0Valid,
  input  logic [15:0] req0Data,
  input  logic [1:0]  req0Lvl,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic [15:0] req1Data,
  input  logic [1:0]  req1Lvl,
  output logic        req1Ready,
  output logic        int0,
  output logic        int1,
  output logic        intLvl1,
  output logic        intLvl0,
  output logic [15:0] intDataIn,
  output logic        intWrite,
  input  logic        intr,
  input  logic [15:0] intDataOut,
  output logic        rspValid,
  output logic        rspLine,
  output logic [15:0] rspData,
  output logic        rspTimeout,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t state, state_n;

  // FIFO entries hold {level, payload}; pointers carry a wrap bit for full/empty
  logic [17:0]   mem0 [DEPTH];
  logic [17:0]   mem1 [DEPTH];
  logic [AW:0]   wptr0, rptr0, wptr1, rptr1;
  logic          full0, full1, ne0, ne1;
  logic          push0, push1, pop0, pop1;
  logic [17:0]   head0, head1;
  logic          pick1;

  logic          run;
  logic          sel_line;
  logic [1:0]    sel_lvl;
  logic [15:0]   sel_data;
  logic [CW-1:0] cnt;
  logic          load_sel, take_ack, take_tmo;
  logic          active;

  assign full0 = (wptr0[AW] != rptr0[AW]) && (wptr0[AW-1:0] == rptr0[AW-1:0]);
  assign full1 = (wptr1[AW] != rptr1[AW]) && (wptr1[AW-1:0] == rptr1[AW-1:0]);
  assign ne0   = (wptr0 != rptr0);
  assign ne1   = (wptr1 != rptr1);

  // Ready is held low during reset and rises on the first edge after release
  assign req0Ready = run && !full0;
  assign req1Ready = run && !full1;

  assign push0 = req0Valid && req0Ready;
  assign push1 = req1Valid && req1Ready;
  assign pop0  = (state == ISSUE) && !sel_line;
  assign pop1  = (state == ISSUE) && sel_line;

  assign head0 = mem0[rptr0[AW-1:0]];
  assign head1 = mem1[rptr1[AW-1:0]];

  // Higher head level wins; a tie or an empty line 1 falls to line 0
  assign pick1 = ne1 && (!ne0 || (head1[17:16] > head0[17:16]));

  // Payload storage is not reset; pointer reset alone empties the FIFOs
  always_ff @(posedge CLK) begin
    if (push0) mem0[wptr0[AW-1:0]] <= {req0Lvl, req0Data};
    if (push1) mem1[wptr1[AW-1:0]] <= {req1Lvl, req1Data};
  end

  // FIFO pointers and the post-reset ready enable
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wptr0 <= '0;
      rptr0 <= '0;
      wptr1 <= '0;
      rptr1 <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push0) wptr0 <= wptr0 + PW'(1);
      if (pop0)  rptr0 <= rptr0 + PW'(1);
      if (push1) wptr1 <= wptr1 + PW'(1);
      if (pop1)  rptr1 <= rptr1 + PW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; an ack on the timeout cycle takes precedence over the abort
  always_comb begin
    state_n  = state;
    load_sel = 1'b0;
    take_ack = 1'b0;
    take_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (ne0 || ne1) begin
          load_sel = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (intr) begin
          take_ack = 1'b1;
          state_n  = GAP;
        end else if ((TIMEOUT != 0) && (cnt == TMO_LAST)) begin
          take_tmo = 1'b1;
          state_n  = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Selected request capture, wait counter and response registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sel_line   <= 1'b0;
      sel_lvl    <= 2'd0;
      sel_data   <= 16'd0;
      cnt        <= '0;
      rspValid   <= 1'b0;
      rspLine    <= 1'b0;
      rspData    <= 16'd0;
      rspTimeout <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      if (load_sel) begin
        sel_line <= pick1;
        sel_lvl  <= pick1 ? head1[17:16] : head0[17:16];
        sel_data <= pick1 ? head1[15:0]  : head0[15:0];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && cnt != {CW{1'b1}}) begin
        cnt <= cnt + CW'(1);
      end
      if (take_ack) begin
        rspValid   <= 1'b1;
        rspLine    <= sel_line;
        rspData    <= intDataOut;
        rspTimeout <= 1'b0;
      end else if (take_tmo) begin
        rspValid   <= 1'b1;
        rspLine    <= sel_line;
        rspData    <= 16'd0;
        rspTimeout <= 1'b1;
      end
    end
  end

  // Interrupt lines decode straight from state so reset drops them at once
  assign active    = (state == ISSUE) || (state == WAIT);
  assign int0      = active && !sel_line;
  assign int1      = active && sel_line;
  assign intLvl1   = active && sel_lvl[1];
  assign intLvl0   = active && sel_lvl[0];
  assign intDataIn = active ? sel_data : 16'd0;
  assign intWrite  = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_interrupt_source_ctrl.sv
// tb/tb_interrupt_source_ctrl.sv - directed self-checking bench for interrupt_source_ctrl
module tb_interrupt_source_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        req0Valid = 1'b0;
  logic [15:0] req0Data = 16'd0;
  logic [1:0]  req0Lvl = 2'd0;
  logic        req0Ready;
  logic        req1Valid = 1'b0;
  logic [15:0] req1Data = 16'd0;
  logic [1:0]  req1Lvl = 2'd0;
  logic        req1Ready;
  logic        int0, int1, intLvl1, intLvl0, intWrite;
  logic [15:0] intDataIn;
  logic        intr = 1'b0;
  logic [15:0] intDataOut = 16'd0;
  logic        rspValid, rspLine, rspTimeout, busy;
  logic [15:0] rspData;

  int n_chk  = 0;
  int n_pass = 0;

  interrupt_source_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0Valid(req0Valid), .req0Data(req0Data), .req0Lvl(req0Lvl), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Data(req1Data), .req1Lvl(req1Lvl), .req1Ready(req1Ready),
    .int0(int0), .int1(int1), .intLvl1(intLvl1), .intLvl0(intLvl0),
    .intDataIn(intDataIn), .intWrite(intWrite),
    .intr(intr), .intDataOut(intDataOut),
    .rspValid(rspValid), .rspLine(rspLine), .rspData(rspData), .rspTimeout(rspTimeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Entered in IDLE with the request at the head; leaves in IDLE after GAP
  task automatic serve(input string tag, input logic ln, input logic [1:0] lv,
                       input logic [15:0] d, input logic [15:0] ack);
    step();
    chk({tag, "_wr"},   32'(intWrite), 32'd1);
    chk({tag, "_int"},  32'({int1, int0}), ln ? 32'd2 : 32'd1);
    chk({tag, "_lvl"},  32'({intLvl1, intLvl0}), 32'(lv));
    chk({tag, "_data"}, 32'(intDataIn), 32'(d));
    step();
    chk({tag, "_wait_wr"}, 32'(intWrite), 32'd0);
    intr = 1'b1;
    intDataOut = ack;
    step();
    chk({tag, "_rsp"},  32'({rspValid, rspTimeout, rspLine}), {29'd0, 1'b1, 1'b0, ln});
    chk({tag, "_rspd"}, 32'(rspData), 32'(ack));
    chk({tag, "_gap"},  32'({int1, int0, intWrite}), 32'd0);
    intr = 1'b0;
    step();
    chk({tag, "_idle_rsp"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_outs", 32'({int0, int1, intWrite, rspValid, rspTimeout, busy, req0Ready, req1Ready}), 32'd0);
    chk("rst_data", 32'({intDataIn, rspData}), 32'd0);
    step();
    Reset = 1'b1;
    step();
    chk("rst_rel_ready", 32'({req0Ready, req1Ready}), 32'd3);

    // Reset applied mid-WAIT drops everything and discards the queued line-1 entry
    req0Valid = 1'b1; req0Data = 16'h1111; req0Lvl = 2'd0;
    req1Valid = 1'b1; req1Data = 16'h2222; req1Lvl = 2'd0;
    step();
    req0Valid = 1'b0; req1Valid = 1'b0;
    step();
    step();
    chk("t1_in_wait", 32'({busy, int0}), 32'd3);
    #1 Reset = 1'b0;
    #1;
    chk("t1_async", 32'({int0, int1, intWrite, rspValid, busy}), 32'd0);
    step();
    Reset = 1'b1;
    step();
    chk("t1_ready", 32'(req0Ready), 32'd1);
    step();
    chk("t1_discard", 32'(busy), 32'd0);

    // Single request with ack
    req0Valid = 1'b1; req0Data = 16'h1234; req0Lvl = 2'd1;
    step();
    req0Valid = 1'b0;
    chk("t2_no_wr_yet", 32'(intWrite), 32'd0);
    serve("t2", 1'b0, 2'd1, 16'h1234, 16'hBEEF);
    chk("t2_idle", 32'(busy), 32'd0);

    // Priority: higher level wins, tie goes to line 0
    req0Valid = 1'b1; req0Data = 16'hA001; req0Lvl = 2'd1;
    req1Valid = 1'b1; req1Data = 16'hB003; req1Lvl = 2'd3;
    step();
    req0Valid = 1'b0; req1Valid = 1'b0;
    serve("t3a", 1'b1, 2'd3, 16'hB003, 16'h0C01);
    serve("t3b", 1'b0, 2'd1, 16'hA001, 16'h0C02);
    req0Valid = 1'b1; req0Data = 16'hA002; req0Lvl = 2'd2;
    req1Valid = 1'b1; req1Data = 16'hB002; req1Lvl = 2'd2;
    step();
    req0Valid = 1'b0; req1Valid = 1'b0;
    serve("t3c", 1'b0, 2'd2, 16'hA002, 16'h0C03);
    serve("t3d", 1'b1, 2'd2, 16'hB002, 16'h0C04);

    // Fill line 1 while line 0 is held in WAIT
    req0Valid = 1'b1; req0Data = 16'h0F00; req0Lvl = 2'd0;
    step();
    req0Valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      req1Valid = 1'b1; req1Data = 16'h5000 + 16'(i); req1Lvl = 2'(i);
      step();
    end
    chk("t4_full", 32'(req1Ready), 32'd0);
    req1Data = 16'h5004; req1Lvl = 2'd3;
    step();
    chk("t4_still_full", 32'(req1Ready), 32'd0);
    req1Valid = 1'b0;
    intr = 1'b1; intDataOut = 16'h0F0F;
    step();
    chk("t4_l0_rsp", 32'({rspValid, rspLine, rspData}), {15'd0, 1'b1, 1'b0, 16'h0F0F});
    intr = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      serve($sformatf("t4_e%0d", i), 1'b1, 2'(i), 16'h5000 + 16'(i), 16'h6000 + 16'(i));
    chk("t4_empty", 32'({req1Ready, busy}), 32'd2);

    // Timeout after 8 WAIT cycles with no ack
    req0Valid = 1'b1; req0Data = 16'h7777; req0Lvl = 2'd2;
    step();
    req0Valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) step();
    chk("t5_wait8", 32'({rspValid, busy, int0}), 32'd3);
    step();
    chk("t5_tmo", 32'({rspValid, rspTimeout, rspLine}), 32'd6);
    chk("t5_tmo_data", 32'(rspData), 32'd0);
    chk("t5_gap", 32'({int0, int1}), 32'd0);
    step();
    chk("t5_idle", 32'({rspValid, busy}), 32'd0);

    // Ack on the 8th WAIT cycle beats the timeout
    req0Valid = 1'b1; req0Data = 16'h8888; req0Lvl = 2'd2;
    step();
    req0Valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) step();
    intr = 1'b1; intDataOut = 16'hCAFE;
    step();
    intr = 1'b0;
    chk("t5_ack8", 32'({rspValid, rspTimeout}), 32'd2);
    chk("t5_ack8_data", 32'(rspData), 32'hCAFE);
    step();

    // intr held high through ISSUE is only taken once in WAIT
    req1Valid = 1'b1; req1Data = 16'h9999; req1Lvl = 2'd2;
    intr = 1'b1; intDataOut = 16'hD00D;
    step();
    req1Valid = 1'b0;
    step();
    chk("t6_issue", 32'({intWrite, int1}), 32'd3);
    step();
    chk("t6_wait", 32'({rspValid, int1, intWrite}), 32'd2);
    step();
    intr = 1'b0;
    chk("t6_ack", 32'({rspValid, rspLine, rspTimeout}), 32'd6);
    chk("t6_ack_data", 32'(rspData), 32'hD00D);
    chk("t6_gap", 32'({int0, int1, busy}), 32'd1);
    step();
    chk("t6_idle", 32'({busy, rspValid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
